// File: rtl/text_memory_loader.sv
// Streams a little-endian byte feed into 32-bit words and writes them to text memory
// at ascending word-aligned addresses while the core is held in reset.
module text_memory_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] num_words,
    input  logic                  abort,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CW        = ADDR_WIDTH - 1;
    localparam int unsigned MAX_WORDS = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_idx;
    logic [DATA_WIDTH-9:0]   r_word;
    logic [CW-1:0]           r_num_words;
    logic [CW-1:0]           r_word_cnt;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_we;
    logic                    r_done;
    logic                    r_error;
    logic                    r_busy;
    logic                    r_byte_ready;
    logic                    w_last_word;

    assign w_last_word = (r_word_cnt + CW'(1)) == r_num_words;

    // abort lands in the same cycle as WRITE/DONE, so it must mask those strobes directly
    assign we         = r_we & ~abort;
    assign done       = r_done & ~abort;
    assign error      = r_error;
    assign busy       = r_busy;
    assign byte_ready = r_byte_ready;
    assign addr       = r_addr;
    assign data_out   = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_word       <= '0;
            r_num_words  <= '0;
            r_word_cnt   <= '0;
            r_waddr      <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
            r_byte_ready <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (32'(num_words) > MAX_WORDS) begin
                            r_error <= 1'b1;
                        end else begin
                            r_num_words  <= num_words;
                            r_word_cnt   <= '0;
                            r_waddr      <= '0;
                            r_idx        <= '0;
                            r_state      <= RECV;
                            r_busy       <= 1'b1;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (abort) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_byte_ready <= 1'b0;
                        r_idx        <= '0;
                    end else if (byte_valid && r_byte_ready) begin
                        case (r_idx)
                            2'd0: r_word[7:0]   <= byte_in;
                            2'd1: r_word[15:8]  <= byte_in;
                            2'd2: r_word[23:16] <= byte_in;
                            default: begin
                                r_data       <= {byte_in, r_word};
                                r_addr       <= r_waddr;
                                r_we         <= 1'b1;
                                r_byte_ready <= 1'b0;
                                r_state      <= WRITE;
                            end
                        endcase
                        r_idx <= r_idx + 2'd1;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_word_cnt <= r_word_cnt + CW'(1);
                        if (w_last_word) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_waddr      <= r_waddr + ADDR_WIDTH'(4);
                            r_idx        <= '0;
                            r_state      <= RECV;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_memory_loader.sv
// Randomized scoreboard bench for text_memory_loader: expected writes/done/error events
// are queued per session and checked in order by a negedge monitor.
module tb_text_memory_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  num_words;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        byte         kind;
        logic [7:0]  a;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          we_cycles[$];
    logic [31:0] fixed_words[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    text_memory_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .we(we), .addr(addr), .data_out(data_out), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: pops the scoreboard on every strobe and checks per-cycle invariants
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (!rst) begin
            checks++;
            if (addr[1:0] != 2'b00 || (byte_ready && !busy)) begin
                errors++;
                $display("FAIL invariant: addr=%h byte_ready=%b busy=%b, required aligned addr and byte_ready only while busy",
                         addr, byte_ready, busy);
            end
            if (we) begin
                we_cycles.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected we addr=%h data=%h, required none", addr, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != "W" || addr !== e.a || data_out !== e.d) begin
                        errors++;
                        $display("FAIL write: got we addr=%h data=%h, required %s addr=%h data=%h",
                                 addr, data_out, string'(e.kind), e.a, e.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != "D") begin
                    errors++;
                    $display("FAIL done: unexpected done pulse, pending events %0d", exp_q.size());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (error) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != "E") begin
                    errors++;
                    $display("FAIL error: unexpected error pulse, pending events %0d", exp_q.size());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_ev(input byte k, input logic [7:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (we !== 1'b0 || done !== 1'b0 || error !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 ||
            addr !== 8'h00 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL %s: we=%b done=%b error=%b busy=%b ready=%b addr=%h data=%h, required all zero",
                     tag, we, done, error, busy, byte_ready, addr, data_out);
        end
    endtask

    // One load session; abort_k / rst_k cut the stream after that many accepted bytes
    task automatic run_session(input int nw, input int abort_k, input int rst_k,
                               input bit gappy, input bit pester);
        logic [31:0] words[$];
        logic [7:0]  bytes[$];
        logic [31:0] w;
        int          idx;
        int          budget;
        int          nexp;
        bit          took;
        bit          exp_busy;

        if (nw >= 1 && nw <= 64) begin
            for (int i = 0; i < nw; i++) begin
                w = (i < fixed_words.size()) ? fixed_words[i] : $urandom;
                words.push_back(w);
                for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
            end
        end

        if (nw == 0) push_ev("D", 8'h00, 32'h0);
        else if (nw > 64) push_ev("E", 8'h00, 32'h0);
        else if (rst_k == 0) begin
            nexp = (abort_k > 0) ? (abort_k - 1) / 4 : nw;
            for (int j = 0; j < nexp; j++) push_ev("W", 8'(4 * j), words[j]);
            if (abort_k == 0) push_ev("D", 8'h00, 32'h0);
        end

        // stray bytes while idle must not be captured
        byte_valid = 1'b1;
        byte_in = 8'($urandom);
        @(posedge clk); #1;

        byte_valid = 1'b0;
        start = 1'b1;
        num_words = 7'(nw);
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = (nw <= 64);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy_after_start: nw=%0d busy=%b, required %b", nw, busy, exp_busy);
        end
        if (nw == 0 || nw > 64) begin
            repeat (3) begin @(posedge clk); #1; end
            return;
        end

        idx = 0;
        budget = 0;
        while (idx < 4 * nw && budget < 5000) begin
            budget++;
            byte_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_k > 0 && idx == rst_k) byte_valid = 1'b1;
            byte_in = byte_valid ? bytes[idx] : 8'($urandom);
            start = pester ? ($urandom_range(0, 3) == 0) : 1'b0;
            num_words = 7'($urandom);
            took = byte_valid && byte_ready;
            if (rst_k > 0 && idx == rst_k && took) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("reset_mid_session");
                @(posedge clk); #1;
                rst = 1'b0;
                byte_valid = 1'b0;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (abort_k > 0 && idx == abort_k) begin
                    byte_valid = 1'b0;
                    start = 1'b0;
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    break;
                end
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
        if (budget >= 5000) begin
            errors++;
            $display("FAIL byte_timeout: accepted %0d bytes, required %0d", idx, 4 * nw);
        end

        budget = 0;
        while (busy && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_end: busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int nw;
        int ak;
        rst = 1'b1;
        start = 1'b0;
        num_words = '0;
        abort = 1'b0;
        byte_in = '0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

        fixed_words = '{32'h00052503};
        run_session(1, 0, 0, 1'b0, 1'b0);

        fixed_words = '{32'h00052503, 32'h0085a583, 32'h00a58633};
        we_cycles.delete();
        run_session(3, 0, 0, 1'b0, 1'b0);
        checks++;
        if (we_cycles.size() != 3 || we_cycles[1] - we_cycles[0] != 5 || we_cycles[2] - we_cycles[1] != 5) begin
            errors++;
            $display("FAIL write_spacing: %0d writes, required 3 writes 5 cycles apart", we_cycles.size());
        end

        fixed_words = '{};
        run_session(2, 0, 0, 1'b1, 1'b0);
        run_session(0, 0, 0, 1'b0, 1'b0);
        run_session(65, 0, 0, 1'b0, 1'b0);
        run_session(127, 0, 0, 1'b0, 1'b0);
        run_session(64, 0, 0, 1'b0, 1'b0);
        run_session(2, 2, 0, 1'b0, 1'b0);
        run_session(3, 8, 0, 1'b0, 1'b0);
        run_session(2, 5, 0, 1'b1, 1'b0);
        run_session(1, 0, 3, 1'b0, 1'b0);
        run_session(4, 0, 0, 1'b1, 1'b1);

        for (int s = 0; s < 25; s++) begin
            nw = $urandom_range(0, 6);
            ak = (nw > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * nw) : 0;
            run_session(nw, ak, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
